// File: rtl/asciiram_seg_scan.sv
// Scans the ASCII display RAM one character per digit and drives a multiplexed,
// active-low seven-segment display with per-digit dwell and anti-ghost blanking.
module asciiram_seg_scan #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DWELL  = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StHold} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] frame_base;
    logic [IW-1:0]     idx_nxt;

    assign idx_nxt = idx + IW'(1);

    // Case-insensitive hex plus '-', everything else blank; dp is always off.
    function automatic logic [7:0] decode(input logic [7:0] c);
        logic [7:0] s;
        case (c)
            8'h30: s = 8'hC0;
            8'h31: s = 8'hF9;
            8'h32: s = 8'hA4;
            8'h33: s = 8'hB0;
            8'h34: s = 8'h99;
            8'h35: s = 8'h92;
            8'h36: s = 8'h82;
            8'h37: s = 8'hF8;
            8'h38: s = 8'h80;
            8'h39: s = 8'h90;
            8'h41, 8'h61: s = 8'h88;
            8'h42, 8'h62: s = 8'h83;
            8'h43, 8'h63: s = 8'hC6;
            8'h44, 8'h64: s = 8'hA1;
            8'h45, 8'h65: s = 8'h86;
            8'h46, 8'h66: s = 8'h8E;
            8'h2D: s = 8'hBF;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            idx        <= '0;
            cnt        <= '0;
            frame_base <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            seg        <= 8'hFF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en && state != StIdle) begin
                state <= StIdle;
                seg   <= 8'hFF;
                an    <= '1;
                rd_en <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        seg   <= 8'hFF;
                        an    <= '1;
                        rd_en <= 1'b0;
                        if (en) begin
                            idx        <= '0;
                            frame_base <= base_addr;
                            rd_addr    <= base_addr;
                            rd_en      <= 1'b1;
                            state      <= StFetch;
                        end
                    end
                    StFetch: begin
                        rd_en <= 1'b0;
                        state <= StWait;
                    end
                    StWait: begin
                        seg   <= decode(rd_data);
                        an    <= ~(DIGITS'(1) << idx);
                        cnt   <= '0;
                        state <= StHold;
                    end
                    StHold: begin
                        if (cnt == CNT_MAX) begin
                            // Blank before the next fetch so the old glyph never shows on the new anode.
                            an    <= '1;
                            rd_en <= 1'b1;
                            state <= StFetch;
                            if (idx == LAST_IDX) begin
                                idx        <= '0;
                                frame_base <= base_addr;
                                rd_addr    <= base_addr;
                                frame_done <= 1'b1;
                            end else begin
                                idx     <= idx_nxt;
                                rd_addr <= frame_base + ADDR_W'(idx_nxt);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_asciiram_seg_scan.sv
// Directed bench for asciiram_seg_scan: 4 digits, dwell 4, behavioural 1-cycle-latency RAM.
module tb_asciiram_seg_scan;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] base_addr = 8'h10;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame_done;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    asciiram_seg_scan #(.ADDR_W(8), .DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .base_addr  (base_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_blank(input string tag);
        check_eq({tag, "_seg"}, seg, 8'hFF);
        check_eq({tag, "_an"}, an, 4'hF);
        check_eq({tag, "_rd_en"}, rd_en, 1'b0);
        check_eq({tag, "_fd"}, frame_done, 1'b0);
    endtask

    task automatic check_reset_vals();
        check_blank("reset");
        check_eq("reset_rd_addr", rd_addr, 8'h00);
    endtask

    // Advance on falling edges until a fetch cycle, bounded.
    task automatic wait_fetch();
        int n = 0;
        while (rd_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("fetch_timeout", rd_en, 1'b1);
    endtask

    // Entered at the falling edge inside a FETCH cycle; returns inside the next FETCH.
    task automatic digit(input logic [7:0] addr, input logic [7:0] s, input logic [3:0] a,
                         input logic fd);
        check_eq("fetch_rd_en", rd_en, 1'b1);
        check_eq("fetch_rd_addr", rd_addr, addr);
        check_eq("fetch_an", an, 4'hF);
        check_eq("fetch_fd", frame_done, fd);
        @(negedge clk);
        check_eq("wait_rd_en", rd_en, 1'b0);
        check_eq("wait_an", an, 4'hF);
        for (int k = 0; k < DWELL; k++) begin
            @(negedge clk);
            check_eq("hold_seg", seg, s);
            check_eq("hold_an", an, a);
            check_eq("hold_rd_en", rd_en, 1'b0);
        end
        @(negedge clk);
    endtask

    logic [7:0] sw_chr [28];
    logic [7:0] sw_seg [28];
    logic [3:0] an_tbl [4];
    logic [7:0] s1234  [4];

    initial begin
        sw_chr = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
                   8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                   8'h2D, 8'h20, 8'h7F, 8'h47, 8'h38, 8'h00};
        sw_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90,
                   8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
                   8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
                   8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFF};
        an_tbl = '{4'hE, 4'hD, 4'hB, 4'h7};
        s1234  = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;
        mem[8'h10] = "1"; mem[8'h11] = "2"; mem[8'h12] = "3"; mem[8'h13] = "4";
        for (int i = 0; i < 28; i++) mem[8'h20 + i] = sw_chr[i];
        mem[8'h40] = "A"; mem[8'h41] = "B"; mem[8'h42] = "C"; mem[8'h43] = "D";
        mem[8'hFE] = "5"; mem[8'hFF] = "6"; mem[8'h00] = "7"; mem[8'h01] = "8";

        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        wait_fetch();

        // Basic frame, then frame period.
        for (int d = 0; d < 4; d++) digit(8'h10 + d[7:0], s1234[d], an_tbl[d], 1'b0);
        check_eq("frame_done_first", frame_done, 1'b1);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (frame_done !== 1'b1 && n < 100);
            check_eq("frame_period", n, 24);
        end

        // Decode sweep, seven frames starting at 0x20.
        base_addr = 8'h20;
        for (int d = 0; d < 4; d++) digit(8'h10 + d[7:0], s1234[d], an_tbl[d], d == 0);
        for (int f = 0; f < 7; f++) begin
            base_addr = (f < 6) ? 8'h20 + 8'(4 * (f + 1)) : 8'h10;
            for (int d = 0; d < 4; d++)
                digit(8'h20 + 8'(4 * f + d), sw_seg[4 * f + d], an_tbl[d], d == 0);
        end

        // base_addr change during digit 2 must not tear the current frame.
        digit(8'h10, 8'hF9, 4'hE, 1'b1);
        digit(8'h11, 8'hA4, 4'hD, 1'b0);
        base_addr = 8'h40;
        digit(8'h12, 8'hB0, 4'hB, 1'b0);
        digit(8'h13, 8'h99, 4'h7, 1'b0);
        base_addr = 8'hFE;
        digit(8'h40, 8'h88, 4'hE, 1'b1);
        digit(8'h41, 8'h83, 4'hD, 1'b0);
        digit(8'h42, 8'hC6, 4'hB, 1'b0);
        digit(8'h43, 8'hA1, 4'h7, 1'b0);

        // Address wrap.
        base_addr = 8'h10;
        digit(8'hFE, 8'h92, 4'hE, 1'b1);
        digit(8'hFF, 8'h82, 4'hD, 1'b0);
        digit(8'h00, 8'hF8, 4'hB, 1'b0);
        digit(8'h01, 8'h80, 4'h7, 1'b0);

        // en dropped during HOLD of digit 1.
        digit(8'h10, 8'hF9, 4'hE, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("pre_drop_an", an, 4'hD);
        en = 1'b0;
        @(negedge clk);
        check_blank("en_drop");
        repeat (3) @(negedge clk);
        check_blank("en_idle");
        en = 1'b1;
        @(negedge clk);
        check_eq("reen_rd_en", rd_en, 1'b1);
        check_eq("reen_rd_addr", rd_addr, 8'h10);
        digit(8'h10, 8'hF9, 4'hE, 1'b0);

        // Async reset mid-HOLD, between clock edges.
        repeat (3) @(negedge clk);
        check_eq("pre_rst_an", an, 4'hD);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch();
        digit(8'h10, 8'hF9, 4'hE, 1'b0);
        digit(8'h11, 8'hA4, 4'hD, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
